// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 16-bit interval timer with a sticky done flag
module mmio_timer #(
  parameter logic [8:0] BASE     = 9'h180,
  parameter int         PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  inout  wire  [15:0] read_data,
  output logic        done
);
  logic [8:0]  off;
  logic        hit, wr, rd, wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick, fire, expire;
  logic        en, reload;
  logic [15:0] load_v, count, presc, rd_mux;
  assign off       = mem_addr - BASE;
  assign hit       = off < 9'd4;
  assign wr        = mem_cmd == 2'b11 && hit;
  assign rd        = mem_cmd == 2'b01 && hit;
  assign wr_ctrl   = wr && off[1:0] == 2'd0;
  assign wr_load   = wr && off[1:0] == 2'd1;
  assign wr_count  = wr && off[1:0] == 2'd2;
  assign wr_status = wr && off[1:0] == 2'd3;
  assign tick      = en && presc == 16'(PRESCALE - 1);
  // a CPU write to CTRL or COUNT on a tick edge swallows that tick
  assign fire      = tick && !wr_ctrl && !wr_count;
  assign expire    = fire && count == 16'd1;
  // prescaler: free-runs while enabled, restarted by a COUNT write
  always_ff @(posedge clk or negedge reset)
    if (!reset) presc <= '0;
    else presc <= (wr_count || !en || tick) ? '0 : presc + 16'd1;
  // control and reload registers; a one-shot expiry drops EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en     <= 1'b0;
      reload <= 1'b0;
      load_v <= '0;
    end else begin
      en     <= wr_ctrl ? write_data[0] : (expire && !reload) ? 1'b0 : en;
      reload <= wr_ctrl ? write_data[1] : reload;
      load_v <= wr_load ? write_data : load_v;
    end
  // down-counter; old LOAD is used even if LOAD is written on the reload edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= wr_count ? write_data :
                  (fire && count != 16'd0) ? (count == 16'd1 ? (reload ? load_v : 16'd0) : count - 16'd1) :
                  count;
  // sticky done: an expiry beats a simultaneous clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) done <= 1'b0;
    else done <= expire | (done & ~(wr_status & write_data[0]));
  // register select for the combinational read path
  always_comb
    rd_mux = off[1:0] == 2'd0 ? {14'b0, reload, en} :
             off[1:0] == 2'd1 ? load_v :
             off[1:0] == 2'd2 ? count : {15'b0, done};
  assign read_data = rd ? rd_mux : 16'bz;
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer with a reference model and random bus traffic
module tb_mmio_timer;
  localparam int         P = 4;
  localparam logic [8:0] B = 9'h180;
  logic        clk = 1'b0, reset = 1'b0, done;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = 9'h0;
  logic [15:0] write_data = 16'h0;
  wire  [15:0] read_data;
  pullup (read_data);
  mmio_timer #(.BASE(B), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {bit is_done; logic [15:0] exp; string nm;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int   m_pre = 0;
  bit   m_en = 0, m_rl = 0, m_done = 0;
  logic [15:0] m_load = 0, m_count = 0;
  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.nm, e.is_done ? {15'b0, done} : read_data, e.exp);
    end
  end
  function automatic void m_clear();
    m_pre = 0; m_en = 0; m_rl = 0; m_done = 0; m_load = 0; m_count = 0;
  endfunction
  function automatic logic [15:0] mreg(logic [1:0] i);
    case (i)
      2'd0: return {14'b0, m_rl, m_en};
      2'd1: return m_load;
      2'd2: return m_count;
      default: return {15'b0, m_done};
    endcase
  endfunction
  function automatic bit decoded(logic [8:0] a);
    return a >= B && a <= 9'(B + 3);
  endfunction
  function automatic void m_edge(logic [1:0] c, logic [8:0] a, logic [15:0] d);
    bit w, wc, wl, wn, ws, tk, setd;
    logic [1:0] i;
    i = 2'(a - B);
    w = c == 2'b11 && decoded(a);
    wc = w && i == 0; wl = w && i == 1; wn = w && i == 2; ws = w && i == 3;
    tk = m_en && m_pre == P - 1;
    setd = 0;
    m_pre = (wn || !m_en) ? 0 : (m_pre + 1) % P;
    if (tk && !wc && !wn) begin
      if (m_count > 1) m_count = m_count - 1;
      else if (m_count == 1) begin
        setd = 1;
        m_count = m_rl ? m_load : 16'd0;
        if (!m_rl) m_en = 0;
      end
    end
    if (wc) begin m_en = d[0]; m_rl = d[1]; end
    if (wl) m_load = d;
    if (wn) m_count = d;
    m_done = setd | (m_done & !(ws & d[0]));
  endfunction
  function automatic void expect_cycle(logic [1:0] c, logic [8:0] a, string nm);
    q.push_back('{is_done: 1'b0, exp: (c == 2'b01 && decoded(a)) ? mreg(2'(a - B)) : 16'hffff, nm: {nm, "/rd"}});
    q.push_back('{is_done: 1'b1, exp: {15'b0, m_done}, nm: {nm, "/done"}});
  endfunction
  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d, input string nm);
    mem_cmd = c; mem_addr = a; write_data = d;
    expect_cycle(c, a, nm);
    @(posedge clk);
    if (!reset) m_clear(); else m_edge(c, a, d);
    #1;
  endtask
  task automatic wr(input logic [8:0] a, input logic [15:0] d, input string nm);
    cyc(2'b11, a, d, nm);
  endtask
  task automatic rd(input logic [8:0] a, input string nm);
    cyc(2'b01, a, 16'h0, nm);
  endtask
  task automatic idle();
    cyc(2'b00, 9'h0, 16'h0, "idle");
  endtask
  task automatic drop_reset(input logic [8:0] a, input string nm);
    mem_cmd = 2'b01; mem_addr = a;
    #2 reset = 1'b0;
    m_clear();
    expect_cycle(2'b01, a, nm);
    @(posedge clk);
    m_clear();
    #1;
  endtask
  task automatic until_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin idle(); n++; end
  endtask
  logic [8:0] pool [8];
  int n;
  initial begin
    pool = '{B, 9'(B + 1), 9'(B + 2), 9'(B + 3), 9'h100, 9'h140, 9'h184, 9'h17f};
    repeat (2) @(posedge clk);
    #1;
    rd(B + 2, "rst_rd_low");
    idle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) rd(9'(B + i), "rst_reg");
    idle();
    wr(B + 1, 16'd3, "os_load");
    wr(B + 2, 16'd3, "os_count");
    wr(B, 16'd1, "os_ctrl");
    until_done(40, n);
    check("oneshot_latency", 16'(n), 16'd12);
    rd(B + 2, "os_count_end");
    rd(B, "os_ctrl_end");
    wr(B + 3, 16'd1, "os_clear");
    wr(B + 1, 16'd2, "ar_load");
    wr(B + 2, 16'd2, "ar_count");
    wr(B, 16'd3, "ar_ctrl");
    until_done(40, n);
    check("reload_latency", 16'(n), 16'd8);
    rd(B + 2, "ar_count_reload");
    wr(B + 3, 16'd1, "ar_clear");
    until_done(40, n);
    check("reload_period", 16'(n + 2), 16'd8);
    wr(B + 3, 16'd1, "ar_clear2");
    repeat (6) idle();
    wr(B + 3, 16'd1, "set_beats_clear");
    check("set_wins", {15'b0, done}, 16'd1);
    repeat (3) idle();
    wr(B + 2, 16'd5, "count_on_tick");
    rd(B + 2, "count_after_tick_wr");
    repeat (2) idle();
    rd(B + 2, "count_before_dec");
    rd(B + 2, "count_after_dec");
    wr(B, 16'd0, "stop");
    wr(B + 2, 16'd7, "ar_mid_count");
    wr(B, 16'd1, "ar_mid_ctrl");
    repeat (2) idle();
    drop_reset(B + 2, "async_count");
    rd(B, "async_ctrl");
    rd(B + 3, "async_status");
    reset = 1'b1;
    wr(B + 1, 16'h1234, "dec_load");
    wr(B + 2, 16'd9, "dec_count");
    wr(9'h100, 16'hffff, "dec_led");
    wr(9'h140, 16'hffff, "dec_sw");
    wr(9'h184, 16'hffff, "dec_184");
    for (int i = 0; i < 4; i++) rd(9'(B + i), "dec_reg");
    rd(9'h184, "dec_rd184");
    wr(B + 2, 16'd9, "dec_wr_cmd");
    cyc(2'b10, B + 2, 16'hffff, "dec_cmd10");
    rd(B + 2, "dec_count_kept");
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  c;
      logic [8:0]  a;
      logic [15:0] d;
      c = 2'($urandom_range(0, 3));
      a = pool[$urandom_range(0, 7)];
      d = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) begin
        drop_reset(a, "rnd_reset");
        reset = 1'b1;
      end else cyc(c, a, d, "rnd");
    end
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
